// File: rtl/tp_mem_rd_streamer.sv
// Transposer memory read streamer: reads a run of wide words and
// emits each one as OUT_W-bit chunks over a valid/ready stream.
module tp_mem_rd_streamer #(
    parameter int ADDR_W = 6,
    parameter int WORD_W = 2048,
    parameter int OUT_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_cnt,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [WORD_W-1:0] mem_rd_word,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int NCHUNK = WORD_W / OUT_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NCHUNK - 1);
    localparam logic [IDX_W-1:0]  IDX_PEN  = IDX_W'(NCHUNK - 2);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO = '0;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        STREAM,
        DONE
    } state_t;

    state_t                         state_q;
    logic [ADDR_W-1:0]              cur_addr_q;
    logic [ADDR_W:0]                rem_q;
    logic [IDX_W-1:0]               idx_q;
    logic [NCHUNK-1:0][OUT_W-1:0]   buf_q;
    logic                           busy_q;
    logic                           done_q;
    logic                           rd_en_q;
    logic [ADDR_W-1:0]              rd_addr_q;
    logic                           valid_q;
    logic                           last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            rem_q      <= '0;
            idx_q      <= '0;
            buf_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        cur_addr_q <= base_addr;
                        rem_q      <= word_cnt;
                        busy_q     <= 1'b1;
                        if (word_cnt != CNT_ZERO) begin
                            state_q   <= READ;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= base_addr;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    state_q <= CAPT;
                end
                CAPT: begin
                    buf_q      <= mem_rd_word;
                    idx_q      <= '0;
                    cur_addr_q <= cur_addr_q + ADDR_ONE;
                    rem_q      <= rem_q - CNT_ONE;
                    state_q    <= STREAM;
                    valid_q    <= 1'b1;
                    // single-chunk words are last as soon as they appear
                    last_q     <= (NCHUNK == 1) && (rem_q == CNT_ONE);
                end
                STREAM: begin
                    if (out_ready) begin
                        if (idx_q != IDX_LAST) begin
                            idx_q  <= idx_q + IDX_ONE;
                            last_q <= (idx_q == IDX_PEN) &&
                                      (rem_q == CNT_ZERO);
                        end else begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            if (rem_q != CNT_ZERO) begin
                                state_q   <= READ;
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= cur_addr_q;
                            end else begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;
    assign out_valid   = valid_q;
    assign out_last    = last_q;
    assign out_data    = valid_q ? buf_q[idx_q] : '0;

endmodule

// File: tb/tb_tp_mem_rd_streamer.sv
// Scoreboard bench for tp_mem_rd_streamer: expected reads, chunks and
// done pulses are queued at command issue and retired by monitors.
module tb_tp_mem_rd_streamer;

    localparam int ADDR_W = 6;
    localparam int WORD_W = 2048;
    localparam int OUT_W  = 64;
    localparam int NCHUNK = WORD_W / OUT_W;
    localparam int NWORDS = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_cnt;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [WORD_W-1:0] mem_rd_word;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    tp_mem_rd_streamer #(
        .ADDR_W(ADDR_W),
        .WORD_W(WORD_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_cnt   (word_cnt),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_word(mem_rd_word),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    int n_vec;
    int n_err;
    int hs_cnt;
    int done_pend;
    bit rnd_en;
    bit exp_done_nxt;

    logic [WORD_W-1:0] mem [NWORDS];
    logic [OUT_W-1:0]  dq[$];
    logic              lq[$];
    int                aq[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] cv(input int a, input int c);
        if (a == 5) return OUT_W'(c);
        return {16'hA5A5, 16'(a), 32'(c)};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk)
        if (mem_rd_en) mem_rd_word <= mem[mem_rd_addr];

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_en ? ($urandom_range(0, 99) < 60) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                if (aq.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_addr", 64'(mem_rd_addr), 64'(aq.pop_front()));
            end
            if (out_valid) begin
                if (dq.size() == 0) begin
                    chk("valid_unexpected", 1, 0);
                end else begin
                    chk("data", out_data, dq[0]);
                    chk("last", 64'(out_last), 64'(lq[0]));
                    if (out_ready) begin
                        void'(dq.pop_front());
                        void'(lq.pop_front());
                        hs_cnt++;
                    end
                end
            end else begin
                chk("data_idle", out_data, 0);
            end
            if (exp_done_nxt) chk("done_timing", 64'(done), 1);
            exp_done_nxt = out_valid && out_ready && out_last;
            if (done) begin
                chk("done_expected", 64'(done_pend != 0), 1);
                if (done_pend != 0) done_pend--;
            end
        end
    end

    task automatic cmd(input int base, input int cnt, input bit lat);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        word_cnt  = (ADDR_W + 1)'(cnt);
        for (int w = 0; w < cnt; w++) begin
            int a = (base + w) % NWORDS;
            aq.push_back(a);
            for (int c = 0; c < NCHUNK; c++) begin
                dq.push_back(cv(a, c));
                lq.push_back((w == cnt - 1) && (c == NCHUNK - 1));
            end
        end
        done_pend++;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 1);
        if (cnt == 0) begin
            chk("zc_done", 64'(done), 1);
            chk("zc_rd_en", 64'(mem_rd_en), 0);
            chk("zc_valid", 64'(out_valid), 0);
        end
        if (lat) begin
            chk("lat_rd_en", 64'(mem_rd_en), 1);
            chk("lat_rd_addr", 64'(mem_rd_addr), 64'(base));
            @(posedge clk);
            #1;
            chk("lat_valid_k1", 64'(out_valid), 0);
            chk("lat_rd_en_k1", 64'(mem_rd_en), 0);
            @(posedge clk);
            #1;
            chk("lat_valid_k2", 64'(out_valid), 1);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((dq.size() != 0 || done_pend != 0 || busy) && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", 64'(n < 20000), 1);
        chk("aq_drained", 64'(aq.size()), 0);
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_cnt < target && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("hs_timeout", 64'(n < 20000), 1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        hs_cnt = 0;
        done_pend = 0;
        rnd_en = 1'b0;
        exp_done_nxt = 1'b0;
        start = 1'b0;
        base_addr = '0;
        word_cnt = '0;
        for (int a = 0; a < NWORDS; a++)
            for (int c = 0; c < NCHUNK; c++)
                mem[a][c*OUT_W +: OUT_W] = cv(a, c);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_rd_en", 64'(mem_rd_en), 0);
        chk("rst_rd_addr", 64'(mem_rd_addr), 0);
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", 64'(out_last), 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        cmd(5, 1, 1'b1);
        wait_idle();

        cmd(62, 3, 1'b0);
        wait_idle();

        rnd_en = 1'b1;
        cmd(20, 4, 1'b0);
        wait_idle();
        rnd_en = 1'b0;

        cmd(0, 0, 1'b0);
        wait_idle();

        cmd(30, 2, 1'b0);
        wait_hs(hs_cnt + 5);
        start     = 1'b1;
        base_addr = ADDR_W'(7);
        word_cnt  = (ADDR_W + 1)'(5);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        rnd_en = 1'b1;
        cmd(40, 64, 1'b0);
        wait_idle();
        rnd_en = 1'b0;

        cmd(10, 4, 1'b0);
        wait_hs(hs_cnt + 2 * NCHUNK + 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_done", 64'(done), 0);
        chk("mid_rst_rd_en", 64'(mem_rd_en), 0);
        chk("mid_rst_rd_addr", 64'(mem_rd_addr), 0);
        chk("mid_rst_valid", 64'(out_valid), 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_last", 64'(out_last), 0);
        dq.delete();
        lq.delete();
        aq.delete();
        done_pend = 0;
        exp_done_nxt = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_no_done", 64'(done), 0);
        cmd(50, 2, 1'b1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
